// File: rtl/boss_attack_ctrl.sv
// Boss projectile scheduler: cooldown/burst FSM, bullet slot pool, movement and pixel render.
// Optional BOSS_AIMED_SHOT_EN adds player_x_pos and per-slot horizontal drift toward the player.
module boss_attack_ctrl #(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int BURST_LEN       = 3,
    parameter int BURST_GAP       = 8,
    parameter int BULLET_STEP     = 4,
    parameter int BULLET_HALF     = 3,
    parameter int SPAWN_DY        = 60,
    parameter int Y_MAX           = 479,
    parameter int ENRAGE_HITS     = 5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [9:0]           boss_x_pos,
    input  logic [9:0]           boss_y_pos,
    input  logic [3:0]           hit_count,
    input  logic                 is_boss_dead,
    input  logic [NUM_SLOTS-1:0] bullet_hit,
`ifdef BOSS_AIMED_SHOT_EN
    input  logic [9:0]           player_x_pos,
`endif
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    output logic                 is_boss_bullet,
    output logic [NUM_SLOTS-1:0] active_mask,
    output logic                 fire_pulse,
    output logic [1:0]           attack_state
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int BW = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;
    localparam int GW = (BURST_GAP > 0) ? $clog2(BURST_GAP + 1) : 1;
    localparam logic signed [10:0] HALF = 11'(BULLET_HALF);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COOL = 2'd1, ST_BURST = 2'd2, ST_DEAD = 2'd3} state_t;

    state_t                      r_state;
    logic                        r_fc_s, r_fc_d, r_tick, r_fire;
    logic [CW-1:0]               r_cnt;
    logic [BW-1:0]               r_shots;
    logic [GW-1:0]               r_gap;
    logic [NUM_SLOTS-1:0]        r_act;
    logic [NUM_SLOTS-1:0][9:0]   r_x, r_y;
    logic [NUM_SLOTS-1:0][9:0]   w_xnew, w_ynew;
    logic [NUM_SLOTS-1:0]        w_ret, w_in;
    logic                        w_free_any, w_spawn;
    logic [SW-1:0]               w_free_idx;
`ifdef BOSS_AIMED_SHOT_EN
    logic [NUM_SLOTS-1:0][1:0]   r_dx;
    logic [1:0]                  w_spawn_dx;
    assign w_spawn_dx = (player_x_pos > boss_x_pos) ? 2'b01 :
                        (player_x_pos < boss_x_pos) ? 2'b11 : 2'b00;
`endif

    // Spawn target comes from the registered mask, so a slot freed this tick waits one more tick.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!r_act[i]) begin
                w_free_any = 1'b1;
                w_free_idx = SW'(i);
            end
    end

    assign w_spawn = r_tick && (r_state == ST_BURST) && (r_gap == '0) && w_free_any && !is_boss_dead;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic [10:0]        w_ynext;
        logic signed [10:0] w_ddx, w_ddy;
        assign w_ynext = {1'b0, r_y[i]} + 11'(BULLET_STEP);
        assign w_ynew[i] = w_ynext[9:0];
`ifdef BOSS_AIMED_SHOT_EN
        logic [11:0] w_xnext;
        assign w_xnext   = {2'b00, r_x[i]} + {{10{r_dx[i][1]}}, r_dx[i]};
        assign w_xnew[i] = w_xnext[9:0];
        assign w_ret[i]  = (w_ynext > 11'(Y_MAX)) || w_xnext[11] || (w_xnext > 12'd639);
`else
        assign w_xnew[i] = r_x[i];
        assign w_ret[i]  = w_ynext > 11'(Y_MAX);
`endif
        assign w_ddx   = $signed({1'b0, DrawX}) - $signed({1'b0, r_x[i]});
        assign w_ddy   = $signed({1'b0, DrawY}) - $signed({1'b0, r_y[i]});
        assign w_in[i] = (w_ddx >= -HALF) && (w_ddx <= HALF) && (w_ddy >= -HALF) && (w_ddy <= HALF);
    end

    assign is_boss_bullet = |(w_in & r_act);
    assign active_mask    = r_act;
    assign fire_pulse     = r_fire;
    assign attack_state   = r_state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_fc_s  <= 1'b0;
            r_fc_d  <= 1'b0;
            r_tick  <= 1'b0;
            r_fire  <= 1'b0;
            r_cnt   <= '0;
            r_shots <= '0;
            r_gap   <= '0;
            r_act   <= '0;
            r_x     <= '0;
            r_y     <= '0;
`ifdef BOSS_AIMED_SHOT_EN
            r_dx    <= '0;
`endif
        end else begin
            r_fc_s <= frame_clk;
            r_fc_d <= r_fc_s;
            r_tick <= r_fc_s & ~r_fc_d;
            r_fire <= w_spawn;

            if (is_boss_dead) begin
                r_state <= ST_DEAD;
            end else if (r_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_COOL;
                        r_cnt   <= CW'(COOLDOWN_FRAMES);
                    end
                    ST_COOL: begin
                        if (r_cnt <= CW'(1)) begin
                            r_state <= ST_BURST;
                            r_cnt   <= '0;
                            r_shots <= BW'(BURST_LEN);
                            r_gap   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    ST_BURST: begin
                        if (r_gap != '0) begin
                            r_gap <= r_gap - GW'(1);
                        end else if (w_free_any) begin
                            if (r_shots <= BW'(1)) begin
                                r_state <= ST_COOL;
                                r_shots <= '0;
                                r_cnt   <= (hit_count >= 4'(ENRAGE_HITS)) ? CW'(COOLDOWN_FRAMES >> 1)
                                                                          : CW'(COOLDOWN_FRAMES);
                            end else begin
                                r_shots <= r_shots - BW'(1);
                                r_gap   <= GW'(BURST_GAP);
                            end
                        end
                    end
                    default: r_state <= ST_DEAD;
                endcase
            end

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (r_act[i] && bullet_hit[i]) begin
                    r_act[i] <= 1'b0;
                end else if (w_spawn && (w_free_idx == SW'(i))) begin
                    r_act[i] <= 1'b1;
                    r_x[i]   <= boss_x_pos;
                    r_y[i]   <= boss_y_pos + 10'(SPAWN_DY);
`ifdef BOSS_AIMED_SHOT_EN
                    r_dx[i]  <= w_spawn_dx;
`endif
                end else if (r_tick && r_act[i]) begin
                    if (w_ret[i]) begin
                        r_act[i] <= 1'b0;
                    end else begin
                        r_x[i] <= w_xnew[i];
                        r_y[i] <= w_ynew[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_boss_attack_ctrl.sv
// Directed bench for boss_attack_ctrl: 4-slot instance for scheduling/movement, 2-slot instance for pool exhaustion.
module tb_boss_attack_ctrl;
    logic       Clk = 1'b0;
    logic       Reset, frame_clk, dead;
    logic [9:0] boss_x, boss_y, DrawX, DrawY;
    logic [3:0] hit_cnt;
    logic [3:0] bhit1;
    logic [1:0] bhit2;
    logic       bb1, bb2, fire1, fire2;
    logic [3:0] mask1;
    logic [1:0] mask2, st1, st2;
    int         total = 0, bad = 0, n_fire1 = 0, n_fire2 = 0;

    always #5 Clk = ~Clk;

    boss_attack_ctrl dut1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .boss_x_pos(boss_x), .boss_y_pos(boss_y), .hit_count(hit_cnt),
        .is_boss_dead(dead), .bullet_hit(bhit1),
`ifdef BOSS_AIMED_SHOT_EN
        .player_x_pos(boss_x),
`endif
        .DrawX(DrawX), .DrawY(DrawY),
        .is_boss_bullet(bb1), .active_mask(mask1), .fire_pulse(fire1), .attack_state(st1)
    );

    boss_attack_ctrl #(.NUM_SLOTS(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .boss_x_pos(boss_x), .boss_y_pos(boss_y), .hit_count(hit_cnt),
        .is_boss_dead(dead), .bullet_hit(bhit2),
`ifdef BOSS_AIMED_SHOT_EN
        .player_x_pos(boss_x),
`endif
        .DrawX(DrawX), .DrawY(DrawY),
        .is_boss_bullet(bb2), .active_mask(mask2), .fire_pulse(fire2), .attack_state(st2)
    );

    always @(negedge Clk) begin
        if (fire1) n_fire1++;
        if (fire2) n_fire2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One frame: 8 Clk cycles; state update lands on the 3rd posedge after frame_clk rises.
    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Same frame, with bullet_hit held across exactly the cycle where the tick is consumed.
    task automatic tick_hit(input logic [3:0] m);
        @(negedge Clk) frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        bhit1 = m;
        @(negedge Clk) bhit1 = 4'b0;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk) Reset = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; dead = 1'b0;
        boss_x = 10'd320; boss_y = 10'd160; hit_cnt = 4'd0;
        bhit1 = 4'b0; bhit2 = 2'b0; DrawX = 10'd320; DrawY = 10'd220;
        repeat (3) @(negedge Clk);
        chk("rst_state", st1, 0);
        chk("rst_mask", mask1, 0);
        chk("rst_fire", fire1, 0);
        chk("rst_pix", bb1, 0);
        Reset = 1'b0;

        // Phase 1: nominal schedule, boss at (320,160)
        ticks(1);  chk("t1_cool", st1, 1);
        ticks(59); chk("t60_cool", st1, 1);
        ticks(1);  chk("t61_burst", st1, 2);
        chk("t61_mask", mask1, 0);
        chk("t61_nfire", n_fire1, 0);
        ticks(1);  chk("t62_mask", mask1, 4'b0001);
        chk("t62_nfire", n_fire1, 1);
        chk("t62_mask2", mask2, 2'b01);
        pix(320, 220); chk("pix_ctr", bb1, 1);
        pix(323, 223); chk("pix_edge", bb1, 1);
        pix(324, 220); chk("pix_outx", bb1, 0);
        pix(320, 216); chk("pix_outy", bb1, 0);
        pix(317, 217); chk("pix_neg", bb1, 1);
        ticks(8);  chk("t70_mask", mask1, 4'b0001);
        chk("t70_nfire", n_fire1, 1);
        ticks(1);  chk("t71_mask", mask1, 4'b0011);
        chk("t71_nfire", n_fire1, 2);
        pix(320, 256); chk("t71_pix_moved", bb1, 1);
        ticks(8);  chk("t79_burst", st1, 2);
        ticks(1);  chk("t80_cool", st1, 1);
        chk("t80_mask", mask1, 4'b0111);
        chk("t80_nfire", n_fire1, 3);
        chk("t80_st2_held", st2, 2);
        chk("t80_mask2", mask2, 2'b11);
        chk("t80_nfire2", n_fire2, 2);
        ticks(46); chk("t126_mask2", mask2, 2'b11);
        chk("t126_nfire2", n_fire2, 2);
        ticks(1);  chk("t127_mask2", mask2, 2'b10);
        chk("t127_nfire2", n_fire2, 2);
        chk("t127_st2", st2, 2);
        chk("t127_mask1", mask1, 4'b0110);
        ticks(1);  chk("t128_mask2", mask2, 2'b11);
        chk("t128_nfire2", n_fire2, 3);
        chk("t128_st2", st2, 1);
        pix(320, 220); chk("t128_pix2", bb2, 1);
        ticks(8);  chk("t136_mask1", mask1, 4'b0100);
        ticks(3);  chk("t139_cool", st1, 1);
        ticks(1);  chk("t140_burst", st1, 2);
        ticks(1);  chk("t141_mask1", mask1, 4'b0101);
        chk("t141_nfire", n_fire1, 4);

        do_reset();
        chk("rst2_mask1", mask1, 0);
        chk("rst2_mask2", mask2, 0);
        chk("rst2_st1", st1, 0);
        chk("rst2_st2", st2, 0);
        pix(320, 220); chk("rst2_pix", bb1, 0);
        n_fire1 = 0; n_fire2 = 0;
        Reset = 1'b0;

        // Phase 2: bottom-edge retirement, hit, enrage, death
        boss_y = 10'd416;
        ticks(61); chk("p2_t61_burst", st1, 2);
        ticks(1);  chk("p2_t62_mask", mask1, 4'b0001);
        pix(320, 476); chk("y476_pix", bb1, 1);
        pix(320, 479); chk("y476_pix_dy3", bb1, 1);
        pix(320, 480); chk("y476_pix_dy4", bb1, 0);
        pix(317, 476); chk("y476_pix_dxm3", bb1, 1);
        pix(316, 476); chk("y476_pix_dxm4", bb1, 0);
        ticks(1);  chk("y476_retired", mask1, 0);
        pix(320, 476); chk("y476_gone_pix", bb1, 0);
        boss_y = 10'd415;
        ticks(8);  chk("y475_spawn", mask1, 4'b0001);
        ticks(1);  chk("y479_alive", mask1, 4'b0001);
        pix(320, 479); chk("y479_pix", bb1, 1);
        pix(320, 475); chk("y479_old_pix", bb1, 0);
        ticks(1);  chk("y479_retired", mask1, 0);
        boss_y = 10'd160; hit_cnt = 4'd5;
        ticks(7);  chk("p2_t80_mask", mask1, 4'b0001);
        chk("p2_t80_cool", st1, 1);
        chk("p2_t80_nfire", n_fire1, 3);
        tick_hit(4'b0001);
        chk("hit_mask", mask1, 0);
        pix(320, 224); chk("hit_pix", bb1, 0);
        ticks(28); chk("enr_t109_cool", st1, 1);
        ticks(1);  chk("enr_t110_burst", st1, 2);
        ticks(1);  chk("p2_t111_mask", mask1, 4'b0001);
        chk("p2_t111_nfire", n_fire1, 4);
        dead = 1'b1;
        ticks(1);  chk("dead_state", st1, 3);
        pix(320, 224); chk("dead_pix_moved", bb1, 1);
        pix(320, 220); chk("dead_pix_old", bb1, 0);
        ticks(13); chk("dead_nfire", n_fire1, 4);
        chk("dead_mask", mask1, 4'b0001);
        chk("dead_state2", st1, 3);
        ticks(50); chk("dead_t175_mask", mask1, 4'b0001);
        ticks(1);  chk("dead_t176_mask", mask1, 0);
        chk("dead_t176_state", st1, 3);

        do_reset();
        chk("rst3_state", st1, 0);
        chk("rst3_mask", mask1, 0);
        dead = 1'b0;
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/boss_attack_ctrl.md
Name: boss_attack_ctrl

Overview:
Schedules the boss's projectile attacks in the final game. Sequences cooldown and burst phases from the frame clock, allocates shots into a fixed pool of bullet slots, advances and retires bullets, and drives the per-pixel is_boss_bullet signal for the colour mapper. Takes boss position, hit count and death status from the boss sprite block; feeds bullet hit reports back from the collision logic.

Parameters:
NUM_SLOTS, 4, bullet pool size (2..8)
COOLDOWN_FRAMES, 60, frames between bursts
BURST_LEN, 3, shots per burst
BURST_GAP, 8, frames between shots within a burst
BULLET_STEP, 4, downward pixels per frame
BULLET_HALF, 3, half-width of square bullet in pixels
SPAWN_DY, 60, spawn y offset below boss centre
Y_MAX, 479, last visible row
ENRAGE_HITS, 5, hit_count at or above which cooldown halves

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_clk  in  1  vsync-rate frame clock, async to game logic edges
boss_x_pos  in  10  boss centre x
boss_y_pos  in  10  boss centre y
hit_count  in  4  boss hits taken
is_boss_dead  in  1  boss defeated
bullet_hit  in  NUM_SLOTS  one-hot/multi-hot: slot struck player, retire
DrawX, DrawY  in  10  current pixel
is_boss_bullet  out  1  pixel lies inside an active bullet (combinational)
active_mask  out  NUM_SLOTS  slot occupancy
fire_pulse  out  1  one Clk pulse per spawned bullet
attack_state  out  2  IDLE=0, COOLDOWN=1, BURST=2, DEAD=3

Behaviour:
- Reset (synchronous, active-high; clock Clk): state IDLE, all slots inactive, slot x/y = 0, counters 0, fire_pulse 0, active_mask 0. Reset mid-burst clears every bullet immediately.
- Tick: frame_clk sampled into a delay flop; tick = registered rising edge (one Clk pulse per frame, 2 Clk latency from edge). All movement/counting happens only on tick.
- FSM (on tick):
  - IDLE -> COOLDOWN, cnt = COOLDOWN_FRAMES.
  - COOLDOWN: cnt-1; when cnt reaches 0 -> BURST, shots_left = BURST_LEN, gap = 0.
  - BURST: if gap==0: try spawn; on success shots_left-1, gap = BURST_GAP; if no free slot, shot held (not consumed), retry next tick. Else gap-1. When shots_left reaches 0 -> COOLDOWN, cnt = COOLDOWN_FRAMES, or COOLDOWN_FRAMES>>1 if hit_count >= ENRAGE_HITS (sampled at transition).
  - Any state, is_boss_dead=1 -> DEAD (priority over all transitions). DEAD is terminal until Reset; no spawns; live bullets keep moving and retire normally.
- Spawn: lowest-index inactive slot per the registered active_mask (slot freed same tick is not reused until next tick). x = boss_x_pos, y = boss_y_pos + SPAWN_DY. fire_pulse high the Clk cycle the slot is written.
- Move (on tick, each active slot): if y + BULLET_STEP > Y_MAX (11-bit compare, no wrap) -> inactive; else y += BULLET_STEP. Newly spawned bullet does not move on its spawn tick.
- bullet_hit[i]=1 on any Clk: slot i inactive next cycle; priority over move and spawn. Hit on an inactive slot ignored.
- Render: is_boss_bullet = OR over active slots of (|DrawX - x| <= BULLET_HALF and |DrawY - y| <= BULLET_HALF), signed 11-bit differences. Zero when no slot active.

Optional Feature:
BOSS_AIMED_SHOT_EN: adds input player_x_pos[10] and a 2-bit signed dx per slot. At spawn dx = +1 if player_x_pos > boss_x_pos, -1 if less, 0 if equal; each tick x += dx, slot retired if x would leave 0..639. Without the macro: no port, no dx storage, bullets fall vertically.

Test Plan:
- Reset, run 61 frames with boss at (320,160) -> state IDLE->COOLDOWN, BURST entered on tick 61, first fire_pulse, slot0 at (320,220), active_mask=0001.
- Continue 20 frames -> three fire_pulses spaced 8 ticks, active_mask=0111, then state COOLDOWN with cnt=60.
- Set NUM_SLOTS=2, let bullets persist -> third shot held, no fire_pulse until a slot retires, then spawns into freed slot next tick.
- Bullet at y=476 with step 4 -> retired on next tick (480>479); at y=475 -> moves to 479, retires following tick.
- Assert bullet_hit=0001 on the same cycle as a tick -> slot0 inactive, not moved; hit_count=5 at burst end -> cooldown loads 30.
- Assert is_boss_dead mid-burst -> attack_state=3, no further fire_pulse, existing bullets fall and clear; Reset -> IDLE, mask 0.
